// File: rtl/gameport_paddles.sv
// Multi-channel 558-style paddle timer: each strobe loads a scaled, clamped
// count per enabled channel, and pdl stays high while that count drains on CLK_2M ticks.
module gameport_paddles #(
  parameter int CHANNELS     = 4,
  parameter int CENTER       = 2800,
  parameter int GAIN         = 22,
  parameter int CLAMP_THRESH = 5590,
  parameter int MAX_COUNT    = 5650,
  parameter int CNT_W        = 13
) (
  input  logic                  CLK_14M,
  input  logic                  reset,
  input  logic                  CLK_2M,
  input  logic                  PDL_STROBE,
  input  logic [8*CHANNELS-1:0] joy_an,
  input  logic [CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]   ch_en,
  output logic [CHANNELS-1:0]   pdl,
  output logic                  busy
);

  // Wide signed intermediate leaves headroom for large GAIN/CENTER choices.
  localparam int IW = CNT_W + 10;
  localparam logic signed [IW-1:0] CENTER_S = IW'(CENTER);
  localparam logic signed [IW-1:0] GAIN_S   = IW'(GAIN);
  localparam logic signed [IW-1:0] CLAMP_S  = IW'(CLAMP_THRESH);
  localparam logic [CNT_W-1:0]     MAX_C    = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0]     ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] calc_load(input logic [7:0] v, input logic m);
    logic signed [IW-1:0] sv;
    logic signed [IW-1:0] raw;
    logic [CNT_W-1:0]     res;
    if (m) begin
      sv  = $signed({{(IW-8){1'b0}}, v});
      raw = GAIN_S * sv;
    end else begin
      sv  = $signed({{(IW-8){v[7]}}, v});
      raw = CENTER_S + GAIN_S * sv;
    end
    if (raw < $signed({IW{1'b0}})) begin
      res = {CNT_W{1'b0}};
    end else if (raw >= CLAMP_S) begin
      res = MAX_C;
    end else begin
      res = raw[CNT_W-1:0];
    end
    return res;
  endfunction

  logic                clk2m_d;
  logic                tick;
  logic [CNT_W-1:0]    cnt  [CHANNELS];
  logic [CNT_W-1:0]    load [CHANNELS];

  assign tick = ~clk2m_d & CLK_2M;
  assign busy = |pdl;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = calc_load(joy_an[8*i +: 8], mode[i]);
    end
  end

  // Decrement happens first; a strobe load on the same tick overrides it.
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      clk2m_d <= 1'b0;
      pdl     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= {CNT_W{1'b0}};
      end
    end else begin
      clk2m_d <= CLK_2M;
      if (tick) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (cnt[i] != {CNT_W{1'b0}}) begin
            cnt[i] <= cnt[i] - ONE_C;
            pdl[i] <= 1'b1;
          end else begin
            pdl[i] <= 1'b0;
          end
          if (PDL_STROBE && ch_en[i]) begin
            cnt[i] <= load[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gameport_paddles.sv
// Directed bench for gameport_paddles: pulse lengths per mode/value, retrigger,
// enable mask, reset and tick gating, checked with immediate assertions.
module tb_gameport_paddles;

  logic        CLK_14M = 1'b0;
  logic        reset;
  logic        CLK_2M;
  logic        PDL_STROBE;
  logic [31:0] joy_an;
  logic [3:0]  mode;
  logic [3:0]  ch_en;
  logic [3:0]  pdl;
  logic        busy;

  int tests  = 0;
  int failed = 0;
  int len;

  gameport_paddles dut (
    .CLK_14M(CLK_14M), .reset(reset), .CLK_2M(CLK_2M), .PDL_STROBE(PDL_STROBE),
    .joy_an(joy_an), .mode(mode), .ch_en(ch_en), .pdl(pdl), .busy(busy)
  );

  always #5 CLK_14M = ~CLK_14M;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One CLK_2M rising edge; returns at a negedge after the tick has been applied.
  task automatic tick();
    CLK_2M = 1'b1;
    @(negedge CLK_14M);
    CLK_2M = 1'b0;
    @(negedge CLK_14M);
  endtask

  task automatic strobe_tick();
    PDL_STROBE = 1'b1;
    tick();
    PDL_STROBE = 1'b0;
  endtask

  // Counts consecutive high ticks of pdl[idx], starting with the next tick.
  task automatic measure(input int idx, output int n);
    n = 0;
    for (int k = 0; k < 6000; k++) begin
      tick();
      if (pdl[idx]) n++;
      else break;
    end
  endtask

  task automatic run_pulse(input logic [7:0] v, input logic m, output int n);
    joy_an[7:0] = v;
    mode[0]     = m;
    strobe_tick();
    measure(0, n);
  endtask

  initial begin
    int  l0, l2;
    logic other_hi;
    reset = 1'b1; CLK_2M = 1'b0; PDL_STROBE = 1'b0;
    joy_an = 32'h0; mode = 4'b0000; ch_en = 4'b0001;
    @(negedge CLK_14M);
    @(negedge CLK_14M);
    reset = 1'b0;
    @(negedge CLK_14M);
    chk("reset_pdl", int'(pdl), 0);
    chk("reset_busy", int'(busy), 0);

    // Signed centre with busy tracking.
    joy_an[7:0] = 8'h00; mode[0] = 1'b0;
    strobe_tick();
    tick();
    chk("centre_busy_hi", int'(busy), 1);
    measure(0, len);
    chk("centre_len", len + 1, 2800);
    chk("centre_busy_lo", int'(busy), 0);

    run_pulse(8'h80, 1'b0, len); chk("signed_m128", len, 0);
    run_pulse(8'h7F, 1'b0, len); chk("signed_p127", len, 5650);
    run_pulse(8'h7D, 1'b0, len); chk("signed_p125", len, 5550);
    run_pulse(8'd100, 1'b1, len); chk("unsigned_100", len, 2200);
    run_pulse(8'd255, 1'b1, len); chk("unsigned_255", len, 5650);
    run_pulse(8'd0, 1'b1, len);   chk("unsigned_0", len, 0);

    // Retrigger after 1000 ticks with v=-50.
    joy_an[7:0] = 8'h00; mode[0] = 1'b0;
    strobe_tick();
    for (int k = 0; k < 1000; k++) tick();
    chk("retrig_mid", int'(pdl[0]), 1);
    joy_an[7:0] = 8'hCE;
    strobe_tick();
    chk("retrig_cont", int'(pdl[0]), 1);
    measure(0, len);
    chk("retrig_len", len, 1700);

    // Enable mask; ch_en[0] cleared mid-pulse.
    joy_an = 32'h0; mode = 4'b0000; ch_en = 4'b0101;
    strobe_tick();
    l0 = 0; l2 = 0; other_hi = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (k == 100) ch_en[0] = 1'b0;
      tick();
      if (pdl[0]) l0++;
      if (pdl[2]) l2++;
      if (pdl[1] || pdl[3]) other_hi = 1'b1;
      if (!pdl[0] && !pdl[2]) break;
    end
    chk("en_len0", l0, 2800);
    chk("en_len2", l2, 2800);
    chk("en_masked", int'(other_hi), 0);

    // Reset mid-pulse, then no further activity without a strobe.
    ch_en = 4'b0001; joy_an[7:0] = 8'h00;
    strobe_tick();
    for (int k = 0; k < 500; k++) tick();
    chk("rst_pre", int'(pdl[0]), 1);
    reset = 1'b1;
    @(negedge CLK_14M);
    reset = 1'b0;
    chk("rst_pdl", int'(pdl), 0);
    chk("rst_busy", int'(busy), 0);
    other_hi = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pdl != 4'b0000) other_hi = 1'b1;
    end
    chk("rst_no_pulse", int'(other_hi), 0);

    // Tick gating: CLK_2M held low freezes the count.
    joy_an[7:0] = 8'd1; mode[0] = 1'b1;
    strobe_tick();
    for (int k = 0; k < 5; k++) tick();
    for (int k = 0; k < 300; k++) @(negedge CLK_14M);
    chk("freeze_hold", int'(pdl[0]), 1);
    measure(0, len);
    chk("freeze_rest", len, 17);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
